// File: rtl/rfa_pkg.sv
// Shared types for the reg_file_alu sequencer: instruction layout, ALU op codes
// and controller states.
package rfa_pkg;

    localparam int INSTR_W = 24;

    typedef enum logic [1:0] {
        ALU_OP0 = 2'b00,
        ALU_OP1 = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        src_imm;
        logic        wr;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [7:0]  imm;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXEC   = 2'b01,
        COMMIT = 2'b10,
        RESP   = 2'b11
    } ctrl_state_e;

endpackage

// File: rtl/rfa_instr_fifo.sv
// Synchronous instruction queue; full/empty distinguished by an extra pointer wrap bit.
module rfa_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once the write pointer passes them.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_file_alu_ctrl.sv
// Sequencer for reg_file_alu: queues instructions, walks each through EXEC/COMMIT/RESP
// with registered register-file controls, and returns the ALU result on a stream.
module reg_file_alu_ctrl
    import rfa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [23:0]       instr_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_data,
    output logic              busy,
    output logic [15:0]       instr_count,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              rf_alusrc,
    output logic [1:0]        rf_aluctrl,
    input  logic [DATA_W-1:0] rf_alu_result
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and a producer holds its data until the transfer.

    ctrl_state_e state_q;
    instr_t      head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        wr_q;
    logic [15:0] count_q;

    assign instr_ready = !fifo_full;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign instr_count = count_q;

    rfa_instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (instr_valid),
        .pop   (pop),
        .din   (instr_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            count_q      <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            rf_ra1       <= '0;
            rf_ra2       <= '0;
            rf_wa        <= '0;
            rf_wdata     <= '0;
            rf_we        <= 1'b0;
            rf_alusrc    <= 1'b0;
            rf_aluctrl   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= EXEC;
                        wr_q       <= head.wr;
                        rf_ra1     <= ADDR_W'(head.rs1);
                        rf_ra2     <= ADDR_W'(head.rs2);
                        rf_wa      <= ADDR_W'(head.rd);
                        rf_wdata   <= DATA_W'(head.imm);
                        rf_alusrc  <= head.src_imm;
                        rf_aluctrl <= head.alu_op;
                    end
                end
                EXEC: begin
                    // Addresses have been stable a full cycle, so the ALU output is settled here.
                    result_data <= rf_alu_result;
                    rf_we       <= wr_q;
                    state_q     <= COMMIT;
                end
                COMMIT: begin
                    rf_we        <= 1'b0;
                    result_valid <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        count_q      <= count_q + 16'd1;
                        state_q      <= IDLE;
                        wr_q         <= 1'b0;
                        rf_ra1       <= '0;
                        rf_ra2       <= '0;
                        rf_wa        <= '0;
                        rf_wdata     <= '0;
                        rf_alusrc    <= 1'b0;
                        rf_aluctrl   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_alu_ctrl.sv
// Bench for reg_file_alu_ctrl with a behavioural reg_file_alu stand-in and an
// in-order result model checked every cycle.
module tb_reg_file_alu_ctrl;
    import rfa_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [23:0] instr_data = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [7:0]  result_data;
    logic        busy;
    logic [15:0] instr_count;
    logic [3:0]  rf_ra1, rf_ra2, rf_wa;
    logic [7:0]  rf_wdata;
    logic        rf_we;
    logic        rf_alusrc;
    logic [1:0]  rf_aluctrl;
    logic [7:0]  rf_alu_result;

    int checks = 0;
    int failures = 0;
    int rr_mode = 1;           // 0 random, 1 always ready, 2 never ready
    int we_pulses = 0;
    logic [15:0] count_base = '0;
    logic [15:0] retired = '0;

    // Expected entries: {wr, rd, imm, result}
    logic [20:0] exp_q [$];
    logic [7:0]  mregs [16];
    logic [7:0]  rf_regs [16] = '{default: 8'h00};

    reg_file_alu_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data),
        .busy          (busy),
        .instr_count   (instr_count),
        .rf_ra1        (rf_ra1),
        .rf_ra2        (rf_ra2),
        .rf_wa         (rf_wa),
        .rf_wdata      (rf_wdata),
        .rf_we         (rf_we),
        .rf_alusrc     (rf_alusrc),
        .rf_aluctrl    (rf_aluctrl),
        .rf_alu_result (rf_alu_result)
    );

    // ---------------- clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reg_file_alu stand-in
    function automatic logic [7:0] alu_f(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            ALU_OP0: return a & b;
            ALU_OP1: return a | b;
            ALU_ADD: return a + b;
            default: return a - b;
        endcase
    endfunction

    assign rf_alu_result = alu_f(alu_op_e'(rf_aluctrl), rf_regs[rf_ra1],
                                 rf_alusrc ? rf_wdata : rf_regs[rf_ra2]);

    always @(posedge clk) begin
        if (rf_we)
            rf_regs[rf_wa] <= rf_wdata;
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       result_ready = 1'($urandom_range(0, 1));
            1:       result_ready = 1'b1;
            default: result_ready = 1'b0;
        endcase
    end

    // ---------------- check helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process
    instr_t      m_ins;
    logic [7:0]  m_a, m_b, m_res;
    logic [15:0] m_cnt;
    logic        prev_rv = 1'b0, prev_rr = 1'b0, prev_we = 1'b0;
    logic [7:0]  prev_rd = '0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            retired   = '0;
            we_pulses = 0;
            mregs     = rf_regs;
            prev_rv   = 1'b0;
            prev_rr   = 1'b0;
            prev_we   = 1'b0;
        end else begin
            m_cnt = count_base + retired;
            check("instr_count", 32'(instr_count), 32'(m_cnt));
            if (prev_rv && !prev_rr) begin
                check("rv_held", 32'(result_valid), 32'd1);
                check("rdata_held", 32'(result_data), 32'(prev_rd));
            end
            if (rf_we) begin
                we_pulses++;
                check("we_single_cycle", 32'(prev_we), 32'd0);
                check("we_has_instr", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("we_for_wr", 32'(exp_q[0][20]), 32'd1);
                    check("we_wa", 32'(rf_wa), 32'(exp_q[0][19:16]));
                    check("we_wdata", 32'(rf_wdata), 32'(exp_q[0][15:8]));
                end
            end
            if (result_valid && result_ready) begin
                check("result_has_instr", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("result_data", 32'(result_data), 32'(exp_q[0][7:0]));
                    void'(exp_q.pop_front());
                end
                retired = retired + 16'd1;
            end
            if (instr_valid && instr_ready) begin
                m_ins = instr_t'(instr_data);
                m_a   = mregs[m_ins.rs1];
                m_b   = m_ins.src_imm ? m_ins.imm : mregs[m_ins.rs2];
                m_res = alu_f(m_ins.alu_op, m_a, m_b);
                if (m_ins.wr)
                    mregs[m_ins.rd] = m_ins.imm;
                exp_q.push_back({m_ins.wr, m_ins.rd, m_ins.imm, m_res});
            end
            prev_rv = result_valid;
            prev_rr = result_ready;
            prev_rd = result_data;
            prev_we = rf_we;
        end
    end

    // ---------------- driver tasks (entered and left at posedge + 1)
    function automatic instr_t mk(input alu_op_e op, input logic si, input logic wr,
                                  input logic [3:0] rd, input logic [3:0] rs1,
                                  input logic [3:0] rs2, input logic [7:0] imm);
        instr_t i;
        i.alu_op = op; i.src_imm = si; i.wr = wr;
        i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
        return i;
    endfunction

    task automatic send(input instr_t ins);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_data  = ins;
        @(negedge clk);
        while (!instr_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || result_valid) && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (n >= 400) check("idle_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_result(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 30) begin
            n++;
            @(negedge clk);
        end
        if (n >= 30) check("result_timeout", 32'(n), 32'd0);
        check(name, 32'(result_data), 32'(exp));
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence
    logic [15:0] base;
    logic [7:0]  old7;
    logic        saw_pop;

    initial begin
        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 2: load r5=5, r4=4, then ADD / SUB
        rr_mode = 1;
        send(mk(ALU_ADD, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 8'd5));
        send(mk(ALU_ADD, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0, 8'd4));
        wait_idle();
        check("load_r5", 32'(rf_regs[5]), 32'd5);
        check("load_r4", 32'(rf_regs[4]), 32'd4);
        check("load_count", 32'(instr_count), 32'd2);
        check("load_we_pulses", 32'(we_pulses), 32'd2);
        send(mk(ALU_ADD, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 8'd0));
        wait_result(8'd9, "add_5_4");
        wait_idle();
        send(mk(ALU_SUB, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 8'd0));
        wait_result(8'd1, "sub_5_4");
        wait_idle();

        // 3: backpressure
        base = instr_count;
        rr_mode = 2;
        send(mk(ALU_OP1, 1'b0, 1'b0, 4'd0, 4'd5, 4'd4, 8'd0));
        wait_result(8'd5, "or_5_4");
        for (int i = 0; i < 4; i++)
            send(instr_t'(24'($urandom())));
        check("bp_full_ready", 32'(instr_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rv", 32'(result_valid), 32'd1);
            check("bp_rdata", 32'(result_data), 32'd5);
            check("bp_state", 32'(dut.state_q), 32'(RESP));
            check("bp_no_we", 32'(rf_we), 32'd0);
        end
        @(posedge clk); #1;
        rr_mode = 1;
        wait_idle();
        m_cnt = base + 16'd5;
        check("bp_drain_count", 32'(instr_count), 32'(m_cnt));
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: full queue with simultaneous pop
        base = instr_count;
        rr_mode = 2;
        for (int i = 0; i < 5; i++)
            send(instr_t'(24'($urandom())));
        check("full_ready", 32'(instr_ready), 32'd0);
        instr_valid = 1'b1;
        instr_data  = 24'($urandom());
        rr_mode = 1;
        saw_pop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.state_q == IDLE) begin
                saw_pop = 1'b1;
                check("full_pop_ready", 32'(instr_ready), 32'd0);
            end else if (instr_ready) begin
                break;
            end
        end
        check("full_saw_pop", 32'(saw_pop), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_idle();
        m_cnt = base + 16'd6;
        check("full_drain_count", 32'(instr_count), 32'(m_cnt));
        check("full_sb_empty", 32'(exp_q.size()), 32'd0);

        // random traffic
        rr_mode = 0;
        for (int i = 0; i < 80; i++) begin
            send(instr_t'(24'($urandom())));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        rr_mode = 1;
        wait_idle();
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset during COMMIT
        old7 = rf_regs[7];
        send(mk(ALU_ADD, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, old7 ^ 8'hA5));
        send(mk(ALU_ADD, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 8'h11));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.state_q == COMMIT) break;
        end
        check("mid_in_commit", 32'(dut.state_q), 32'(COMMIT));
        check("mid_we_commit", 32'(rf_we), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_we_async", 32'(rf_we), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(instr_ready), 32'd1);
        check("mid_count", 32'(instr_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("mid_r7_kept", 32'(rf_regs[7]), 32'(old7));
        reset = 1'b1;
        @(posedge clk); #1;
        send(mk(ALU_ADD, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 8'h3C));
        wait_idle();
        check("post_rst_r7", 32'(rf_regs[7]), 32'h3C);
        check("post_rst_count", 32'(instr_count), 32'd1);

        // 6: counter wrap
        force dut.count_q = 16'hFFFE;
        count_base = 16'hFFFE - retired;
        #1 release dut.count_q;
        send(mk(ALU_OP0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd0, 8'h0F));
        wait_idle();
        check("wrap_ffff", 32'(instr_count), 32'hFFFF);
        send(mk(ALU_OP1, 1'b0, 1'b0, 4'd0, 4'd2, 4'd6, 8'h00));
        wait_idle();
        check("wrap_0000", 32'(instr_count), 32'h0000);
        send(mk(ALU_SUB, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 8'h0C));
        wait_result(8'h30, "wrap_sub_imm");
        wait_idle();
        check("wrap_0001", 32'(instr_count), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
